game_flow_controller: RTL and testbench

Sequences the Flappy-style game datapath that sits between the PS2 space-key decoder and the game renderer. It consumes key events through the existing event/acknowledge handshake and runs the game state machine (idle, running, dead). On each frame tick it updates bird physics, pipe scroll and wrap, score, and collision. Its registered outputs drive the renderer's bird Y, score and three pipe X/Y inputs directly. It replaces the ad-hoc test logic in the top level.

---
 rtl/game_flow_controller.sv | 243 ++++++++++++++++++++++++
 tb/tb_game_flow_controller.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/game_flow_controller.sv
// Flappy-style game sequencer: space-key handshake, IDLE/RUN/DEAD state machine, per-frame physics.
// Define GAME_FLOW_LFSR_EN to draw new gap heights from an 8-bit Galois LFSR instead of a fixed table.

module game_flow_controller #(
  parameter int TICK_DIV   = 833333,
  parameter int GRAVITY    = 1,
  parameter int FLAP_V     = 8,
  parameter int MAX_FALL   = 10,
  parameter int PIPE_SPEED = 2,
  parameter int PIPE_W     = 52,
  parameter int GAP_H      = 120,
  parameter int BIRD_X     = 100,
  parameter int DEAD_HOLD  = 30
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic [1:0]  space_state,
  output logic        space_ack,
  output logic [9:0]  bird_y,
  output logic [15:0] score,
  output logic [9:0]  pipe1_x,
  output logic [9:0]  pipe2_x,
  output logic [9:0]  pipe3_x,
  output logic [9:0]  pipe1_y,
  output logic [9:0]  pipe2_y,
  output logic [9:0]  pipe3_y,
  output logic [1:0]  game_state
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_DEAD = 2'd2} state_t;

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int HW = (DEAD_HOLD > 0) ? $clog2(DEAD_HOLD + 1) : 1;

  localparam logic [TW-1:0]     TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [HW-1:0]     HOLD_LAST = HW'(DEAD_HOLD);
  localparam logic signed [7:0] V_FLAP    = 8'(-FLAP_V);
  localparam logic signed [7:0] V_GRAV    = 8'(GRAVITY);
  localparam logic signed [7:0] V_MAX     = 8'(MAX_FALL);
  localparam logic [9:0]        Y_START   = 10'd228;
  localparam logic [9:0]        Y_FLOOR   = 10'd456;
  localparam logic [9:0]        X_SPEED   = 10'(PIPE_SPEED);
  localparam logic [9:0]        X_WRAP    = 10'(660 - PIPE_SPEED);
  localparam logic [10:0]       W_PIPE    = 11'(PIPE_W);
  localparam logic [10:0]       X_BIRD    = 11'(BIRD_X);
  localparam logic [10:0]       H_GAP     = 11'(GAP_H);
  localparam logic [10:0]       BIRD_M1   = 11'd23;
  localparam logic [2:0][9:0]   X_INIT    = {10'd880, 10'd660, 10'd440};
  localparam logic [2:0][9:0]   Y_INIT    = {10'd300, 10'd200, 10'd100};

  state_t            state_q, state_nxt;
  logic [TW-1:0]     tick_cnt;
  logic              tick, ev, press, hold_done;
  logic signed [7:0] velocity, vel_nxt, vel_inc, vel_step, v_new;
  logic signed [10:0] y_sum;
  logic [9:0]        by_new, bird_nxt;
  logic              floor_hit, collide;
  logic [2:0][9:0]   px_q, py_q, px_new, py_new, px_nxt, py_nxt;
  logic [1:0]        passes;
  logic [16:0]       score_sum;
  logic [15:0]       score_new, score_nxt;
  logic              flap_pending, fp_nxt;
  logic [HW-1:0]     hold_cnt, hold_nxt;

`ifdef GAME_FLOW_LFSR_EN
  logic [7:0] lfsr;
`else
  logic [1:0] gap_idx, gap_run, gap_nxt;

  function automatic logic [9:0] gap_y(input logic [1:0] idx);
    case (idx)
      2'd0:    return 10'd100;
      2'd1:    return 10'd200;
      2'd2:    return 10'd300;
      default: return 10'd150;
    endcase
  endfunction
`endif

  assign tick      = (tick_cnt == TICK_LAST);
  assign ev        = (space_state != 2'd0) && !space_ack;
  assign press     = ev && (space_state == 2'd1);
  assign hold_done = (hold_cnt == HOLD_LAST);

  // One frame of physics from the current registers; only committed on a RUN tick.
  always_comb begin
    // NOTE: every comb output gets a default before any branch, so no latch can be inferred.
    vel_inc   = velocity + V_GRAV;
    vel_step  = flap_pending ? V_FLAP : ((vel_inc > V_MAX) ? V_MAX : vel_inc);
    y_sum     = $signed({1'b0, bird_y}) + $signed({{3{vel_step[7]}}, vel_step});
    by_new    = y_sum[9:0];
    v_new     = vel_step;
    floor_hit = 1'b0;
    if (y_sum < 11'sd0) begin
      by_new = '0;
      v_new  = '0;
    end else if (y_sum >= 11'sd456) begin
      by_new    = Y_FLOOR;
      floor_hit = 1'b1;
    end

    px_new  = px_q;
    py_new  = py_q;
    passes  = '0;
    collide = 1'b0;
`ifndef GAME_FLOW_LFSR_EN
    gap_run = gap_idx;
`endif
    for (int i = 0; i < 3; i++) begin
      if (px_q[i] < X_SPEED) begin
        px_new[i] = px_q[i] + X_WRAP;
`ifdef GAME_FLOW_LFSR_EN
        py_new[i] = 10'd40 + {2'b00, lfsr};
`else
        py_new[i] = gap_y(gap_run);
        gap_run   = gap_run + 2'd1;
`endif
      end else begin
        px_new[i] = px_q[i] - X_SPEED;
      end
      if (({1'b0, px_q[i]} + W_PIPE >= X_BIRD) && ({1'b0, px_new[i]} + W_PIPE < X_BIRD))
        passes = passes + 2'd1;
      if (({1'b0, px_new[i]} + W_PIPE - 11'd1 >= X_BIRD) && ({1'b0, px_new[i]} <= X_BIRD + BIRD_M1) &&
          (({1'b0, by_new} < {1'b0, py_new[i]}) ||
           ({1'b0, by_new} + BIRD_M1 > {1'b0, py_new[i]} + H_GAP - 11'd1)))
        collide = 1'b1;
    end

    score_sum = {1'b0, score} + {15'd0, passes};
    score_new = score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      S_IDLE:  if (press) state_nxt = S_RUN;
      S_RUN:   if (tick && (floor_hit || collide)) state_nxt = S_DEAD;
      S_DEAD:  if (press && hold_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bird_nxt  = bird_y;
    vel_nxt   = velocity;
    score_nxt = score;
    px_nxt    = px_q;
    py_nxt    = py_q;
    fp_nxt    = flap_pending;
    hold_nxt  = hold_cnt;
`ifndef GAME_FLOW_LFSR_EN
    gap_nxt   = gap_idx;
`endif
    case (state_q)
      S_IDLE: if (press) fp_nxt = 1'b1;
      S_RUN: begin
        if (tick) begin
          bird_nxt  = by_new;
          vel_nxt   = v_new;
          score_nxt = score_new;
          px_nxt    = px_new;
          py_nxt    = py_new;
          // A press landing on the tick edge is held for the following tick.
          fp_nxt    = press;
`ifndef GAME_FLOW_LFSR_EN
          gap_nxt   = gap_run;
`endif
        end else if (press) begin
          fp_nxt = 1'b1;
        end
      end
      S_DEAD: begin
        if (press && hold_done) begin
          bird_nxt  = Y_START;
          vel_nxt   = '0;
          score_nxt = '0;
          px_nxt    = X_INIT;
          py_nxt    = Y_INIT;
          fp_nxt    = 1'b0;
          hold_nxt  = '0;
`ifndef GAME_FLOW_LFSR_EN
          gap_nxt   = '0;
`endif
        end else if (tick && !hold_done) begin
          hold_nxt = hold_cnt + HW'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
    if (!resetn) state_q <= S_IDLE;
    else         state_q <= state_nxt;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      tick_cnt     <= '0;
      space_ack    <= 1'b0;
      bird_y       <= Y_START;
      velocity     <= '0;
      score        <= '0;
      px_q         <= X_INIT;
      py_q         <= Y_INIT;
      flap_pending <= 1'b0;
      hold_cnt     <= '0;
    end else begin
      tick_cnt     <= tick ? '0 : tick_cnt + TW'(1);
      space_ack    <= ev;
      bird_y       <= bird_nxt;
      velocity     <= vel_nxt;
      score        <= score_nxt;
      px_q         <= px_nxt;
      py_q         <= py_nxt;
      flap_pending <= fp_nxt;
      hold_cnt     <= hold_nxt;
    end
  end

`ifdef GAME_FLOW_LFSR_EN
  // Right-shift Galois form of x^8+x^6+x^5+x^4+1; free-running in every state.
  always_ff @(posedge clock) begin
    if (!resetn) lfsr <= 8'hA5;
    else         lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? 8'hB8 : 8'h00);
  end
`else
  always_ff @(posedge clock) begin
    if (!resetn) gap_idx <= '0;
    else         gap_idx <= gap_nxt;
  end
`endif

  assign game_state = state_q;
  assign pipe1_x    = px_q[0];
  assign pipe2_x    = px_q[1];
  assign pipe3_x    = px_q[2];
  assign pipe1_y    = py_q[0];
  assign pipe2_y    = py_q[1];
  assign pipe3_y    = py_q[2];

endmodule

// File: tb/tb_game_flow_controller.sv
// Randomized bench for game_flow_controller: a frame-level game model feeds a scoreboard queue
// and an independent monitor compares every registered output each cycle.

module tb_game_flow_controller;

  localparam int TICK_DIV   = 4;
  localparam int GRAVITY    = 1;
  localparam int FLAP_V     = 8;
  localparam int MAX_FALL   = 10;
  localparam int PIPE_SPEED = 2;
  localparam int PIPE_W     = 52;
  localparam int GAP_H      = 120;
  localparam int BIRD_X     = 100;
  localparam int DEAD_HOLD  = 30;
  localparam int BIRD_SIZE  = 24;
  localparam int FLOOR_Y    = 480 - BIRD_SIZE;
  localparam int RUN_CYCLES = 8000;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic [1:0]  space_state = 2'd0;
  logic        space_ack;
  logic [9:0]  bird_y;
  logic [15:0] score;
  logic [9:0]  pipe1_x, pipe2_x, pipe3_x, pipe1_y, pipe2_y, pipe3_y;
  logic [1:0]  game_state;

  game_flow_controller #(.TICK_DIV(TICK_DIV)) dut (
    .clock(clock), .resetn(resetn), .space_state(space_state), .space_ack(space_ack),
    .bird_y(bird_y), .score(score),
    .pipe1_x(pipe1_x), .pipe2_x(pipe2_x), .pipe3_x(pipe3_x),
    .pipe1_y(pipe1_y), .pipe2_y(pipe2_y), .pipe3_y(pipe3_y),
    .game_state(game_state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        ack;
    logic [1:0]  st;
    logic [9:0]  by;
    logic [15:0] sc;
    logic [59:0] pipes;
  } snap_t;

  snap_t exp_q[$];
  int checks = 0;
  int failures = 0;

  // Game model: plain integers, one call per clock edge.
  int m_state, m_by, m_vel, m_score, m_fp, m_ack, m_tcnt, m_hold, m_gidx;
  int m_px[3];
  int m_py[3];
  int gap_tab[4] = '{100, 200, 300, 150};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_new_game();
    m_by = 228; m_vel = 0; m_score = 0; m_fp = 0; m_hold = 0; m_gidx = 0;
    m_px = '{440, 660, 880};
    m_py = '{100, 200, 300};
  endtask

  task automatic model_step(input bit rn, input int ss);
    bit tick, ev, press, dead;
    int vel, s, old;
    if (!rn) begin
      model_new_game();
      m_state = 0; m_ack = 0; m_tcnt = 0;
      return;
    end
    tick   = (m_tcnt == TICK_DIV - 1);
    m_tcnt = tick ? 0 : m_tcnt + 1;
    ev     = (ss != 0) && (m_ack == 0);
    press  = ev && (ss == 1);
    m_ack  = ev ? 1 : 0;
    case (m_state)
      0: if (press) begin m_state = 1; m_fp = 1; end
      1: begin
        if (tick) begin
          vel  = m_fp ? -FLAP_V : ((m_vel + GRAVITY > MAX_FALL) ? MAX_FALL : m_vel + GRAVITY);
          s    = m_by + vel;
          dead = 0;
          if (s < 0) begin m_by = 0; m_vel = 0; end
          else if (s >= FLOOR_Y) begin m_by = FLOOR_Y; m_vel = vel; dead = 1; end
          else begin m_by = s; m_vel = vel; end
          for (int i = 0; i < 3; i++) begin
            old = m_px[i];
            if (old < PIPE_SPEED) begin
              m_px[i] = old + 660 - PIPE_SPEED;
              m_py[i] = gap_tab[m_gidx];
              m_gidx  = (m_gidx + 1) % 4;
            end else begin
              m_px[i] = old - PIPE_SPEED;
            end
            if (old + PIPE_W >= BIRD_X && m_px[i] + PIPE_W < BIRD_X && m_score < 65535) m_score++;
            if (m_px[i] <= BIRD_X + BIRD_SIZE - 1 && m_px[i] + PIPE_W - 1 >= BIRD_X &&
                (m_by < m_py[i] || m_by + BIRD_SIZE - 1 > m_py[i] + GAP_H - 1)) dead = 1;
          end
          if (dead) m_state = 2;
          m_fp = press ? 1 : 0;
        end else if (press) begin
          m_fp = 1;
        end
      end
      default: begin
        if (press && m_hold >= DEAD_HOLD) begin
          model_new_game();
          m_state = 0;
        end else if (tick && m_hold < DEAD_HOLD) begin
          m_hold++;
        end
      end
    endcase
  endtask

  function automatic snap_t model_snap();
    snap_t r;
    r.ack   = m_ack[0];
    r.st    = 2'(m_state);
    r.by    = 10'(m_by);
    r.sc    = 16'(m_score);
    r.pipes = {10'(m_px[0]), 10'(m_py[0]), 10'(m_px[1]), 10'(m_py[1]), 10'(m_px[2]), 10'(m_py[2])};
    return r;
  endfunction

  // Keeps the bird inside the gap of the nearest unpassed pipe; always presses outside RUN.
  function automatic bit autopilot_want();
    int best_x, target;
    if (m_state != 1) return 1'b1;
    best_x = 10000;
    target = 200;
    for (int i = 0; i < 3; i++)
      if (m_px[i] + PIPE_W - 1 >= BIRD_X && m_px[i] < best_x) begin
        best_x = m_px[i];
        target = m_py[i] + 56;
      end
    return (m_by > target) && (m_vel >= 0) && (m_fp == 0);
  endfunction

  initial begin : monitor
    snap_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("space_ack",  64'(space_ack),  64'(e.ack));
        check("game_state", 64'(game_state), 64'(e.st));
        check("bird_y",     64'(bird_y),     64'(e.by));
        check("score",      64'(score),      64'(e.sc));
        check("pipes",      64'({pipe1_x, pipe1_y, pipe2_x, pipe2_y, pipe3_x, pipe3_y}), 64'(e.pipes));
      end
    end
  end

  initial begin : driver
    bit       rn;
    bit [1:0] ss;
    for (int cyc = 0; cyc < RUN_CYCLES; cyc++) begin
      @(negedge clock);
      rn = 1'b1;
      ss = 2'd0;
      if (cyc < 3) rn = 1'b0;
      else if (cyc < 8) ss = 2'd1;
      else if (cyc < 4000 || cyc >= 5400)
        ss = autopilot_want() ? 2'd1 : (($urandom_range(0, 15) == 0) ? 2'd2 : 2'd0);
      else if (cyc < 4600) ss = 2'd0;
      else
        ss = ($urandom_range(0, 15) == 0) ? 2'd1 : (($urandom_range(0, 15) == 0) ? 2'd2 : 2'd0);
      if (cyc == 6500) rn = 1'b0;
      resetn      = rn;
      space_state = ss;
      model_step(rn, int'(ss));
      exp_q.push_back(model_snap());
    end
    @(negedge clock);
    @(negedge clock);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
